// File: rtl/aiclk_key_entry_if.sv
// aiclk_key_entry_if: key/tick inputs and alarm-entry outputs of the key entry block.
interface aiclk_key_entry_if;
   logic       one_second;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] new_alarm_ms_hr;
   logic [3:0] new_alarm_ls_hr;
   logic [3:0] new_alarm_ms_min;
   logic [3:0] new_alarm_ls_min;
   logic       load_new_a;
   logic       entry_active;
   logic [2:0] digit_count;
   logic       entry_error;
   logic       entry_timeout;
   modport slave (
      input  one_second, key_valid, key_code,
      output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
             load_new_a, entry_active, digit_count, entry_error, entry_timeout
   );
   modport master (
      output one_second, key_valid, key_code,
      input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
             load_new_a, entry_active, digit_count, entry_error, entry_timeout
   );
endinterface

// File: rtl/aiclk_key_entry.sv
// aiclk_key_entry: keypad alarm-time entry FSM with validation, rolling digit buffer and inactivity timeout.
module aiclk_key_entry #(
   parameter int TIMEOUT_S = 10
) (
   input  logic            clk,
   input  logic            reset,
   aiclk_key_entry_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_S + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ENTRY = 1'b1;
   logic [0:0]    state_q, state_d;
   logic [15:0]   buf_q, buf_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          load_q, load_d, err_q, err_d, to_q, to_d;
   logic          is_digit, is_set, is_clr, in_entry, valid_t;
   assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
   assign is_set   = bus.key_valid && (bus.key_code == 4'hA);
   assign is_clr   = bus.key_valid && (bus.key_code == 4'hB);
   assign in_entry = (state_q == ENTRY);
   // 24-hour HH:MM check on the buffered digits
   assign valid_t  = (buf_q[15:12] <= 4'd2) &&
                     (buf_q[11:8] <= ((buf_q[15:12] == 4'd2) ? 4'd3 : 4'd9)) &&
                     (buf_q[7:4] <= 4'd5) && (buf_q[3:0] <= 4'd9);
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      tmr_d   = in_entry ? tmr_q : '0;
      load_d  = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;
      if (is_clr) begin
         state_d = IDLE;
         buf_d   = '0;
         cnt_d   = '0;
         tmr_d   = '0;
      end else if (is_digit) begin
         state_d = ENTRY;
         buf_d   = in_entry ? {buf_q[11:0], bus.key_code} : {12'd0, bus.key_code};
         cnt_d   = !in_entry ? 3'd1 : ((cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1);
         tmr_d   = '0;
      end else if (is_set && in_entry) begin
         state_d = IDLE;
         tmr_d   = '0;
         if (cnt_q == 3'd4 && valid_t) begin
            load_d = 1'b1;
         end else begin
            err_d = 1'b1;
            buf_d = '0;
            cnt_d = '0;
         end
      end else if (in_entry && bus.one_second) begin
         // ignored codes fall through here, so they neither clear nor block the timer
         if (tmr_q == TW'(TIMEOUT_S - 1)) begin
            to_d    = 1'b1;
            state_d = IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         load_q  <= load_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end
   assign bus.new_alarm_ms_hr  = buf_q[15:12];
   assign bus.new_alarm_ls_hr  = buf_q[11:8];
   assign bus.new_alarm_ms_min = buf_q[7:4];
   assign bus.new_alarm_ls_min = buf_q[3:0];
   assign bus.load_new_a       = load_q;
   assign bus.entry_error      = err_q;
   assign bus.entry_timeout    = to_q;
   assign bus.entry_active     = in_entry;
   assign bus.digit_count      = cnt_q;
endmodule
